// File: rtl/cdc_sync_bus_pkg.sv
// Shared constants and helpers for the cdc_sync_bus synchronizer family.
package cdc_pkg;

  localparam int MIN_STAGES = 2;

  // Returns the number of bits needed to hold values 0..v-1 (at least 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cdc_sync_bus_if.sv
// Bundle of asynchronous inputs and synchronized outputs for cdc_sync_bus.
interface cdc_sync_bus_if import cdc_pkg::*; #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output async_in,
    input  sync_out,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  async_in,
    output sync_out,
    output rise,
    output fall,
    output changed
  );

endinterface

// File: rtl/cdc_sync_bus_bit.sv
// One synchronizer channel: flop chain, optional debounce filter and
// registered rise/fall pulses aligned with the visible sync_o change.
module cdc_sync_bit import cdc_pkg::*; #(
  parameter int   STAGES        = 2,
  parameter int   FILTER        = 0,
  parameter logic RESET_VAL_BIT = 1'b0
) (
  input  logic clk_dest,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] stage_q;
  logic s;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk_dest) begin
    if (rst) stage_q <= {STAGES{RESET_VAL_BIT}};
    else     stage_q <= {stage_q[STAGES-2:0], async_i};
  end

  assign s = stage_q[STAGES-1];

  generate
    if (FILTER == 0) begin : g_bypass
      // The last chain flop is the history of the one before it, so the edge
      // pulse is registered on the same clock that makes the new s visible.
      logic s_next;
      assign s_next = stage_q[STAGES-2];

      always_ff @(posedge clk_dest) begin
        if (rst) begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          rise_q <= s_next & ~s;
          fall_q <= ~s_next & s;
        end
      end

      assign sync_o = s;
    end else begin : g_filter
      localparam int            CW       = clog2(FILTER + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          sync_q, sync_d;
      logic          rise_d, fall_d;

      always_comb begin
        cnt_d  = '0;
        sync_d = sync_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s != sync_q) begin
          if (cnt_q == CNT_LAST) begin
            sync_d = s;
            rise_d = s;
            fall_d = ~s;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk_dest) begin
        if (rst) begin
          cnt_q  <= '0;
          sync_q <= RESET_VAL_BIT;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          sync_q <= sync_d;
          rise_q <= rise_d;
          fall_q <= fall_d;
        end
      end

      assign sync_o = sync_q;
    end
  endgenerate

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/cdc_sync_bus.sv
// WIDTH independent single-bit synchronizers into clk_dest, with a combined
// "any edge this cycle" flag. No cross-bit coherency is provided.
module cdc_sync_bus import cdc_pkg::*; #(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = 2,
  parameter int               FILTER    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic           clk_dest,
  input logic           rst,
  cdc_sync_bus_if.slave bus
);

  generate
    if (STAGES < MIN_STAGES) begin : g_chk_stages
      $error("cdc_sync_bus: STAGES must be at least 2");
    end
    if (WIDTH < 1) begin : g_chk_width
      $error("cdc_sync_bus: WIDTH must be at least 1");
    end
    if (FILTER < 0) begin : g_chk_filter
      $error("cdc_sync_bus: FILTER must be non-negative");
    end
  endgenerate

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    cdc_sync_bit #(
      .STAGES        (STAGES),
      .FILTER        (FILTER),
      .RESET_VAL_BIT (RESET_VAL[i])
    ) u_bit (
      .clk_dest (clk_dest),
      .rst      (rst),
      .async_i  (bus.async_in[i]),
      .sync_o   (sync_w[i]),
      .rise_o   (rise_w[i]),
      .fall_o   (fall_w[i])
    );
  end

  assign bus.sync_out = sync_w;
  assign bus.rise     = rise_w;
  assign bus.fall     = fall_w;
  assign bus.changed  = |(rise_w | fall_w);

endmodule

// File: tb/tb_cdc_sync_bus.sv
// Directed bench for cdc_sync_bus: three instances cover bypass, deep
// chain with filter, and non-zero reset value with filter.
module tb_cdc_sync_bus;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #7 clk = ~clk;

  cdc_sync_bus_if #(.WIDTH(4)) if0 ();
  cdc_sync_bus_if #(.WIDTH(4)) if1 ();
  cdc_sync_bus_if #(.WIDTH(4)) if2 ();

  cdc_sync_bus #(.WIDTH(4), .STAGES(2), .FILTER(0), .RESET_VAL(4'b0000))
    u0 (.clk_dest(clk), .rst(rst), .bus(if0));
  cdc_sync_bus #(.WIDTH(4), .STAGES(3), .FILTER(4), .RESET_VAL(4'b0000))
    u1 (.clk_dest(clk), .rst(rst), .bus(if1));
  cdc_sync_bus #(.WIDTH(4), .STAGES(2), .FILTER(4), .RESET_VAL(4'b1010))
    u2 (.clk_dest(clk), .rst(rst), .bus(if2));

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.async_in = 4'b0000;
    if1.async_in = 4'b0000;
    if2.async_in = 4'b1010;
    tick(4);
    n_tests++;
    if (if0.sync_out !== 4'b0000 || if0.rise !== 4'b0000 || if0.fall !== 4'b0000 || if0.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u0: sync=%b rise=%b fall=%b chg=%b expected 0000/0000/0000/0", if0.sync_out, if0.rise, if0.fall, if0.changed);
    end
    n_tests++;
    if (if1.sync_out !== 4'b0000 || if1.rise !== 4'b0000 || if1.fall !== 4'b0000 || if1.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u1: sync=%b rise=%b fall=%b chg=%b expected 0000/0000/0000/0", if1.sync_out, if1.rise, if1.fall, if1.changed);
    end
    n_tests++;
    if (if2.sync_out !== 4'b1010 || if2.rise !== 4'b0000 || if2.fall !== 4'b0000 || if2.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u2: sync=%b rise=%b fall=%b chg=%b expected 1010/0000/0000/0", if2.sync_out, if2.rise, if2.fall, if2.changed);
    end
    rst = 1'b0;
    tick(3);
    n_tests++;
    if (if2.sync_out !== 4'b1010 || if0.changed !== 1'b0 || if2.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: u2 sync=%b u0 chg=%b u2 chg=%b expected 1010/0/0", if2.sync_out, if0.changed, if2.changed);
    end
  endtask

  task automatic test_basic_latency();
    if0.async_in = 4'b0001;
    tick(1);
    n_tests++;
    if (if0.sync_out !== 4'b0000 || if0.rise !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_edge1: sync=%b rise=%b expected 0000/0000", if0.sync_out, if0.rise);
    end
    tick(1);
    n_tests++;
    if (if0.sync_out !== 4'b0001 || if0.rise !== 4'b0001 || if0.fall !== 4'b0000 || if0.changed !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_edge2: sync=%b rise=%b fall=%b chg=%b expected 0001/0001/0000/1", if0.sync_out, if0.rise, if0.fall, if0.changed);
    end
    tick(1);
    n_tests++;
    if (if0.sync_out !== 4'b0001 || if0.rise !== 4'b0000 || if0.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_edge3: sync=%b rise=%b chg=%b expected 0001/0000/0", if0.sync_out, if0.rise, if0.changed);
    end
    if0.async_in = 4'b0000;
    tick(2);
    n_tests++;
    if (if0.sync_out !== 4'b0000 || if0.fall !== 4'b0001 || if0.rise !== 4'b0000 || if0.changed !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_fall: sync=%b rise=%b fall=%b chg=%b expected 0000/0000/0001/1", if0.sync_out, if0.rise, if0.fall, if0.changed);
    end
    tick(1);
    n_tests++;
    if (if0.fall !== 4'b0000 || if0.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_fall_width: fall=%b chg=%b expected 0000/0", if0.fall, if0.changed);
    end
  endtask

  task automatic test_deeper_chain();
    logic [3:0] exp_sync, exp_rise, exp_fall;
    if1.async_in = 4'b0100;
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      exp_sync = (t >= 7) ? 4'b0100 : 4'b0000;
      exp_rise = (t == 7) ? 4'b0100 : 4'b0000;
      n_tests++;
      if (if1.sync_out !== exp_sync || if1.rise !== exp_rise || if1.fall !== 4'b0000 || if1.changed !== (t == 7)) begin
        n_fail++;
        $display("FAIL deep_rise t=%0d: sync=%b rise=%b fall=%b chg=%b expected %b/%b/0000/%b", t, if1.sync_out, if1.rise, if1.fall, if1.changed, exp_sync, exp_rise, (t == 7));
      end
    end
    if1.async_in = 4'b0000;
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      exp_sync = (t >= 7) ? 4'b0000 : 4'b0100;
      exp_fall = (t == 7) ? 4'b0100 : 4'b0000;
      n_tests++;
      if (if1.sync_out !== exp_sync || if1.fall !== exp_fall || if1.rise !== 4'b0000) begin
        n_fail++;
        $display("FAIL deep_fall t=%0d: sync=%b rise=%b fall=%b expected %b/0000/%b", t, if1.sync_out, if1.rise, if1.fall, exp_sync, exp_fall);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp_sync, exp_rise, exp_fall;
    if1.async_in = 4'b0010;
    tick(3);
    if1.async_in = 4'b0000;
    for (int t = 1; t <= 12; t++) begin
      tick(1);
      n_tests++;
      if (if1.sync_out !== 4'b0000 || if1.rise !== 4'b0000 || if1.fall !== 4'b0000) begin
        n_fail++;
        $display("FAIL glitch3 t=%0d: sync=%b rise=%b fall=%b expected 0000/0000/0000", t, if1.sync_out, if1.rise, if1.fall);
      end
    end
    // A 4-cycle pulse: rise 7 edges after it starts, fall 4 edges later.
    if1.async_in = 4'b0010;
    for (int t = 1; t <= 14; t++) begin
      tick(1);
      if (t == 4) if1.async_in = 4'b0000;
      exp_sync = (t >= 7 && t < 11) ? 4'b0010 : 4'b0000;
      exp_rise = (t == 7)  ? 4'b0010 : 4'b0000;
      exp_fall = (t == 11) ? 4'b0010 : 4'b0000;
      n_tests++;
      if (if1.sync_out !== exp_sync || if1.rise !== exp_rise || if1.fall !== exp_fall) begin
        n_fail++;
        $display("FAIL glitch4 t=%0d: sync=%b rise=%b fall=%b expected %b/%b/%b", t, if1.sync_out, if1.rise, if1.fall, exp_sync, exp_rise, exp_fall);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_sync, exp_rise;
    if2.async_in = 4'b1011;
    tick(4);
    n_tests++;
    if (if2.sync_out !== 4'b1010 || if2.rise !== 4'b0000) begin
      n_fail++;
      $display("FAIL midcount_pre: sync=%b rise=%b expected 1010/0000", if2.sync_out, if2.rise);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_tests++;
    if (if2.sync_out !== 4'b1010 || if2.rise !== 4'b0000 || if2.fall !== 4'b0000 || if2.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_during: sync=%b rise=%b fall=%b chg=%b expected 1010/0000/0000/0", if2.sync_out, if2.rise, if2.fall, if2.changed);
    end
    n_tests++;
    if (if0.sync_out !== 4'b0000 || if1.sync_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_others: u0 sync=%b u1 sync=%b expected 0000/0000", if0.sync_out, if1.sync_out);
    end
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      exp_sync = (t >= 6) ? 4'b1011 : 4'b1010;
      exp_rise = (t == 6) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (if2.sync_out !== exp_sync || if2.rise !== exp_rise || if2.fall !== 4'b0000 || if2.changed !== (t == 6)) begin
        n_fail++;
        $display("FAIL midreset_after t=%0d: sync=%b rise=%b fall=%b chg=%b expected %b/%b/0000/%b", t, if2.sync_out, if2.rise, if2.fall, if2.changed, exp_sync, exp_rise, (t == 6));
      end
    end
  endtask

  task automatic test_simultaneous();
    int chg_count;
    if0.async_in = 4'b0000;
    tick(4);
    if0.async_in = 4'b1111;
    tick(1);
    n_tests++;
    if (if0.rise !== 4'b0000 || if0.changed !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_edge1: rise=%b chg=%b expected 0000/0", if0.rise, if0.changed);
    end
    tick(1);
    n_tests++;
    if (if0.sync_out !== 4'b1111 || if0.rise !== 4'b1111 || if0.fall !== 4'b0000 || if0.changed !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_edge2: sync=%b rise=%b fall=%b chg=%b expected 1111/1111/0000/1", if0.sync_out, if0.rise, if0.fall, if0.changed);
    end
    chg_count = 0;
    for (int t = 0; t < 5; t++) begin
      tick(1);
      if (if0.changed === 1'b1) chg_count++;
    end
    n_tests++;
    if (chg_count !== 0 || if0.sync_out !== 4'b1111) begin
      n_fail++;
      $display("FAIL simul_after: extra changed cycles=%0d sync=%b expected 0/1111", chg_count, if0.sync_out);
    end
  endtask

  initial begin
    if0.async_in = 4'b0000;
    if1.async_in = 4'b0000;
    if2.async_in = 4'b1010;
    test_reset();
    test_basic_latency();
    test_deeper_chain();
    test_glitch();
    test_reset_mid();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
